core_dmem_resp: RTL and testbench

CORE_DMEM_RESP -- requirements
Module: core_dmem_resp

---
 rtl/core_dmem_resp.sv | 194 +++++++++++++++++++
 tb/tb_core_dmem_resp.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/core_dmem_resp.sv
// Wait-stated data-memory responder: captures one load/store request, waits WAIT_CYCLES,
// then performs the aligned access and pulses DONE/ERR with registered outputs.
module core_dmem_resp #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        NRST,
  input  logic        ISLOAD_SS,
  input  logic        ISSTORE_SS,
  input  logic [31:0] ADDR,
  input  logic [3:0]  STRB,
  input  logic [31:0] WDATA,
  input  logic        ISLOADBS,
  input  logic        ISLOADHWS,
  output logic        BUSY,
  output logic [31:0] RDATA,
  output logic        DONE,
  output logic        ERR
);

  localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] DEPTH_LIM = 32'(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;
  typedef enum logic [1:0] {T_NONE, T_LOAD, T_STORE, T_BOTH} req_e;

  state_e      state_q, state_d;
  req_e        type_q, type_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  strb_q, strb_d;
  logic [31:0] wdata_q, wdata_d;
  logic        lbs_q, lbs_d;
  logic        lhs_q, lhs_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic [1:0]       off;
  logic [31:0]      word_idx;
  logic [IDX_W-1:0] mem_idx;
  logic             in_range;
  logic             strb_ok;
  logic             acc_err;
  logic [31:0]      rd_word;
  logic [31:0]      shifted;
  logic [31:0]      load_val;
  logic [31:0]      wr_data;
  logic             mem_we;

  assign off      = addr_q[1:0];
  assign word_idx = {2'b00, addr_q[31:2]};
  assign mem_idx  = addr_q[IDX_W+1:2];
  assign in_range = (word_idx < DEPTH_LIM);
  assign rd_word  = mem[mem_idx];
  assign shifted  = rd_word >> {off, 3'b000};
  assign wr_data  = wdata_q << {off, 3'b000};
  assign acc_err  = !in_range || !strb_ok;
  assign mem_we   = (state_q == S_RESP) && (type_q == T_STORE) && !acc_err;

  // Only naturally aligned byte/halfword/word strobes are legal, and their low lane must equal ADDR[1:0].
  always_comb begin
    strb_ok = 1'b0;
    case (strb_q)
      4'b0001: strb_ok = (off == 2'd0);
      4'b0010: strb_ok = (off == 2'd1);
      4'b0100: strb_ok = (off == 2'd2);
      4'b1000: strb_ok = (off == 2'd3);
      4'b0011: strb_ok = (off == 2'd0);
      4'b1100: strb_ok = (off == 2'd2);
      4'b1111: strb_ok = (off == 2'd0);
      default: strb_ok = 1'b0;
    endcase
  end

  always_comb begin
    load_val = '0;
    case (strb_q)
      4'b0001, 4'b0010, 4'b0100, 4'b1000:
        load_val = {{24{lbs_q & shifted[7]}}, shifted[7:0]};
      4'b0011, 4'b1100:
        load_val = {{16{lhs_q & shifted[15]}}, shifted[15:0]};
      4'b1111:
        load_val = shifted;
      default:
        load_val = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    strb_d  = strb_q;
    wdata_d = wdata_q;
    lbs_d   = lbs_q;
    lhs_d   = lhs_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    busy_d  = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        // busy_q is still high during the DONE cycle, so a request presented then is discarded.
        if (!busy_q && (ISLOAD_SS || ISSTORE_SS)) begin
          addr_d  = ADDR;
          strb_d  = STRB;
          wdata_d = WDATA;
          lbs_d   = ISLOADBS;
          lhs_d   = ISLOADHWS;
          if (ISLOAD_SS && ISSTORE_SS) type_d = T_BOTH;
          else if (ISLOAD_SS)          type_d = T_LOAD;
          else                         type_d = T_STORE;
          cnt_d   = WAIT_INIT;
          state_d = (WAIT_INIT == 4'd0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
        cnt_d   = 4'd0;
        type_d  = T_NONE;
        case (type_q)
          T_BOTH:  err_d = 1'b1;
          T_LOAD: begin
            err_d   = acc_err;
            rdata_d = acc_err ? 32'd0 : load_val;
          end
          T_STORE: err_d = acc_err;
          default: err_d = 1'b0;
        endcase
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state_q <= S_IDLE;
      type_q  <= T_NONE;
      cnt_q   <= '0;
      addr_q  <= '0;
      strb_q  <= '0;
      wdata_q <= '0;
      lbs_q   <= 1'b0;
      lhs_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      strb_q  <= strb_d;
      wdata_q <= wdata_d;
      lbs_q   <= lbs_d;
      lhs_q   <= lhs_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // The array has no reset so its contents survive NRST.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (strb_q[b]) mem[mem_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  assign BUSY  = busy_q;
  assign DONE  = done_q;
  assign ERR   = err_q;
  assign RDATA = rdata_q;

endmodule

// File: tb/tb_core_dmem_resp.sv
// Directed bench: instance A uses WAIT_CYCLES=2/DEPTH 1024, instance B WAIT_CYCLES=0/DEPTH 16.
module tb_core_dmem_resp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ld, st, lbs, lhs;
  logic [31:0] addr, wdata;
  logic [3:0]  strb;
  logic        busy, done, err;
  logic [31:0] rdata;
  logic        z_ld, z_st, z_lbs, z_lhs;
  logic [31:0] z_addr, z_wdata;
  logic [3:0]  z_strb;
  logic        z_busy, z_done, z_err;
  logic [31:0] z_rdata;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  core_dmem_resp #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) u_dut (
    .CLK(clk), .NRST(rst_n), .ISLOAD_SS(ld), .ISSTORE_SS(st), .ADDR(addr), .STRB(strb),
    .WDATA(wdata), .ISLOADBS(lbs), .ISLOADHWS(lhs), .BUSY(busy), .RDATA(rdata), .DONE(done), .ERR(err)
  );

  core_dmem_resp #(.DEPTH_WORDS(16), .WAIT_CYCLES(0)) u_dut0 (
    .CLK(clk), .NRST(rst_n), .ISLOAD_SS(z_ld), .ISSTORE_SS(z_st), .ADDR(z_addr), .STRB(z_strb),
    .WDATA(z_wdata), .ISLOADBS(z_lbs), .ISLOADHWS(z_lhs), .BUSY(z_busy), .RDATA(z_rdata), .DONE(z_done), .ERR(z_err)
  );

  // Present a request for one cycle; returns just after the sampling edge N.
  task automatic issue(input bit sel, input logic l, input logic s, input logic [31:0] a,
                       input logic [3:0] sb, input logic [31:0] wd, input logic bs, input logic hs);
    @(posedge clk); #1;
    if (sel) begin
      z_ld = l; z_st = s; z_addr = a; z_strb = sb; z_wdata = wd; z_lbs = bs; z_lhs = hs;
    end else begin
      ld = l; st = s; addr = a; strb = sb; wdata = wd; lbs = bs; lhs = hs;
    end
    @(posedge clk); #1;
    if (sel) begin z_ld = 1'b0; z_st = 1'b0; end
    else begin ld = 1'b0; st = 1'b0; end
  endtask

  task automatic txn(input bit sel, input logic l, input logic s, input logic [31:0] a,
                     input logic [3:0] sb, input logic [31:0] wd, input logic bs, input logic hs,
                     output int lat, output logic e, output logic [31:0] rd);
    issue(sel, l, s, a, sb, wd, bs, hs);
    lat = -1; e = 1'bx; rd = 'x;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if ((sel ? z_done : done) === 1'b1) begin
        lat = k; e = sel ? z_err : err; rd = sel ? z_rdata : rdata;
        break;
      end
    end
    $display("txn dut=%0d ld=%0b st=%0b addr=%h strb=%b wdata=%h lat=%0d err=%b rdata=%h",
             sel, l, s, a, sb, wd, lat, e, rd);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", done); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", err); end
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h want=0", rdata); end
    total++; if (z_busy !== 1'b0 || z_done !== 1'b0) begin bad++; $display("FAIL rst_z got busy=%b done=%b want 0/0", z_busy, z_done); end
    rst_n = 1'b1;
  endtask

  task automatic test_store_word;
    int lat; logic e; logic [31:0] rd;
    issue(0, 0, 1, 32'h10, 4'hF, 32'hDEADBEEF, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      total++;
      if (busy !== (k <= 3) || done !== (k == 3)) begin
        bad++; $display("FAIL sw_timing cyc=N+%0d got busy=%b done=%b want busy=%b done=%b", k, busy, done, k <= 3, k == 3);
      end
      if (k == 3) begin
        total++; if (err !== 1'b0) begin bad++; $display("FAIL sw_err got=%b want=0", err); end
      end
    end
    txn(0, 1, 0, 32'h10, 4'hF, 32'h0, 0, 0, lat, e, rd);
    total++; if (lat !== 3 || e !== 1'b0 || rd !== 32'hDEADBEEF) begin
      bad++; $display("FAIL lw_10 got lat=%0d err=%b rdata=%h want 3/0/deadbeef", lat, e, rd); end
  endtask

  task automatic test_byte;
    int lat; logic e; logic [31:0] rd;
    txn(0, 0, 1, 32'h13, 4'b1000, 32'h000000A5, 0, 0, lat, e, rd);
    total++; if (lat !== 3 || e !== 1'b0) begin bad++; $display("FAIL sb_13 got lat=%0d err=%b want 3/0", lat, e); end
    txn(0, 1, 0, 32'h13, 4'b1000, 32'h0, 1, 0, lat, e, rd);
    total++; if (e !== 1'b0 || rd !== 32'hFFFFFFA5) begin bad++; $display("FAIL lb_13 got err=%b rdata=%h want 0/ffffffa5", e, rd); end
    txn(0, 1, 0, 32'h13, 4'b1000, 32'h0, 0, 0, lat, e, rd);
    total++; if (e !== 1'b0 || rd !== 32'h000000A5) begin bad++; $display("FAIL lbu_13 got err=%b rdata=%h want 0/000000a5", e, rd); end
    txn(0, 1, 0, 32'h10, 4'hF, 32'h0, 0, 0, lat, e, rd);
    total++; if (rd !== 32'hA5ADBEEF) begin bad++; $display("FAIL lw_merge got=%h want=a5adbeef", rd); end
  endtask

  task automatic test_halfword;
    int lat; logic e; logic [31:0] rd;
    txn(0, 1, 0, 32'h12, 4'b1100, 32'h0, 0, 1, lat, e, rd);
    total++; if (e !== 1'b0 || rd !== 32'hFFFFA5AD) begin bad++; $display("FAIL lh_12 got err=%b rdata=%h want 0/ffffa5ad", e, rd); end
    txn(0, 1, 0, 32'h12, 4'b1100, 32'h0, 0, 0, lat, e, rd);
    total++; if (e !== 1'b0 || rd !== 32'h0000A5AD) begin bad++; $display("FAIL lhu_12 got err=%b rdata=%h want 0/0000a5ad", e, rd); end
    txn(0, 1, 0, 32'h10, 4'b0011, 32'h0, 0, 1, lat, e, rd);
    total++; if (rd !== 32'hFFFFBEEF) begin bad++; $display("FAIL lh_10 got=%h want=ffffbeef", rd); end
    txn(0, 1, 0, 32'h11, 4'b0110, 32'h0, 0, 1, lat, e, rd);
    total++; if (lat !== 3 || e !== 1'b1 || rd !== 32'h0) begin
      bad++; $display("FAIL lh_11_bad got lat=%0d err=%b rdata=%h want 3/1/0", lat, e, rd); end
  endtask

  task automatic test_errors;
    int lat; logic e; logic [31:0] rd;
    txn(0, 0, 1, 32'h1000, 4'hF, 32'h55555555, 0, 0, lat, e, rd);
    total++; if (e !== 1'b1) begin bad++; $display("FAIL st_oor got err=%b want=1", e); end
    txn(0, 1, 0, 32'hFFC, 4'hF, 32'h0, 0, 0, lat, e, rd);
    total++; if (e !== 1'b0) begin bad++; $display("FAIL lw_last_word got err=%b want=0", e); end
    txn(0, 1, 0, 32'h1000, 4'hF, 32'h0, 0, 0, lat, e, rd);
    total++; if (e !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL lw_oor got err=%b rdata=%h want 1/0", e, rd); end
    txn(0, 0, 1, 32'h15, 4'b0001, 32'h000000EE, 0, 0, lat, e, rd);
    total++; if (e !== 1'b1) begin bad++; $display("FAIL sb_lane_mismatch got err=%b want=1", e); end
    txn(0, 1, 0, 32'h10, 4'b0000, 32'h0, 0, 0, lat, e, rd);
    total++; if (e !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL l_strb0 got err=%b rdata=%h want 1/0", e, rd); end
    txn(0, 1, 0, 32'h10, 4'hF, 32'h0, 0, 0, lat, e, rd);
    total++; if (e !== 1'b0 || rd !== 32'hA5ADBEEF) begin bad++; $display("FAIL lw_after_err got err=%b rdata=%h want 0/a5adbeef", e, rd); end
  endtask

  task automatic test_busy_ignore;
    int lat; int n_done; logic e; logic [31:0] rd;
    issue(0, 0, 1, 32'h18, 4'hF, 32'h11112222, 0, 0);
    @(posedge clk); #1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL bi_busy got=%b want=1", busy); end
    ld = 1'b1; addr = 32'h10; strb = 4'hF;
    @(posedge clk); #1;
    ld = 1'b0;
    n_done = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) n_done++;
    end
    total++; if (n_done !== 1) begin bad++; $display("FAIL bi_done_count got=%0d want=1", n_done); end
    total++; if (rdata !== 32'hA5ADBEEF) begin bad++; $display("FAIL bi_rdata_held got=%h want=a5adbeef", rdata); end
    txn(0, 1, 0, 32'h18, 4'hF, 32'h0, 0, 0, lat, e, rd);
    total++; if (rd !== 32'h11112222) begin bad++; $display("FAIL bi_lw_18 got=%h want=11112222", rd); end
  endtask

  task automatic test_back_to_back;
    int lat; int n_done; logic e; logic [31:0] rd;
    // rd holds the DONE-cycle state; a request presented now lands while BUSY is still high.
    txn(0, 1, 0, 32'h10, 4'hF, 32'h0, 0, 0, lat, e, rd);
    ld = 1'b1; addr = 32'h18; strb = 4'hF;
    @(posedge clk); #1;
    ld = 1'b0;
    n_done = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) n_done++;
    end
    total++; if (n_done !== 0) begin bad++; $display("FAIL b2b_done_discard got=%0d want=0", n_done); end
    total++; if (rdata !== 32'hA5ADBEEF) begin bad++; $display("FAIL b2b_rdata got=%h want=a5adbeef", rdata); end
    txn(0, 0, 1, 32'h18, 4'b0011, 32'h0000BBBB, 0, 0, lat, e, rd);
    txn(0, 1, 0, 32'h18, 4'hF, 32'h0, 0, 0, lat, e, rd);
    total++; if (lat !== 3 || rd !== 32'h1111BBBB) begin bad++; $display("FAIL b2b_lw got lat=%0d rdata=%h want 3/1111bbbb", lat, rd); end
  endtask

  task automatic test_reset_midway;
    int lat; int n_done; logic e; logic [31:0] rd;
    txn(0, 0, 1, 32'h20, 4'hF, 32'hCAFEF00D, 0, 0, lat, e, rd);
    issue(0, 0, 1, 32'h20, 4'hF, 32'h12345678, 0, 0);
    @(posedge clk); #1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rm_busy_pre got=%b want=1", busy); end
    rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || done !== 1'b0 || rdata !== 32'h0) begin
      bad++; $display("FAIL rm_async got busy=%b done=%b rdata=%h want 0/0/0", busy, done, rdata); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_done = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) n_done++;
    end
    total++; if (n_done !== 0) begin bad++; $display("FAIL rm_no_done got=%0d want=0", n_done); end
    txn(0, 1, 0, 32'h20, 4'hF, 32'h0, 0, 0, lat, e, rd);
    total++; if (lat !== 3 || rd !== 32'hCAFEF00D) begin bad++; $display("FAIL rm_lw_20 got lat=%0d rdata=%h want 3/cafef00d", lat, rd); end
  endtask

  task automatic test_zero_wait;
    int lat; logic e; logic [31:0] rd;
    txn(1, 0, 1, 32'h4, 4'hF, 32'h0BADC0DE, 0, 0, lat, e, rd);
    total++; if (lat !== 1 || e !== 1'b0) begin bad++; $display("FAIL zw_sw got lat=%0d err=%b want 1/0", lat, e); end
    txn(1, 1, 0, 32'h4, 4'hF, 32'h0, 0, 0, lat, e, rd);
    total++; if (lat !== 1 || rd !== 32'h0BADC0DE) begin bad++; $display("FAIL zw_lw got lat=%0d rdata=%h want 1/0badc0de", lat, rd); end
    txn(1, 1, 1, 32'h4, 4'hF, 32'hFFFFFFFF, 0, 0, lat, e, rd);
    total++; if (lat !== 1 || e !== 1'b1 || rd !== 32'h0BADC0DE) begin
      bad++; $display("FAIL zw_both got lat=%0d err=%b rdata=%h want 1/1/0badc0de", lat, e, rd); end
    txn(1, 1, 0, 32'h6, 4'b1100, 32'h0, 0, 0, lat, e, rd);
    total++; if (e !== 1'b0 || rd !== 32'h00000BAD) begin bad++; $display("FAIL zw_no_write got err=%b rdata=%h want 0/00000bad", e, rd); end
    txn(1, 0, 1, 32'h3C, 4'hF, 32'h76543210, 0, 0, lat, e, rd);
    txn(1, 1, 0, 32'h3C, 4'hF, 32'h0, 0, 0, lat, e, rd);
    total++; if (e !== 1'b0 || rd !== 32'h76543210) begin bad++; $display("FAIL zw_last got err=%b rdata=%h want 0/76543210", e, rd); end
    txn(1, 1, 0, 32'h40, 4'hF, 32'h0, 0, 0, lat, e, rd);
    total++; if (e !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL zw_oor got err=%b rdata=%h want 1/0", e, rd); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ld = 0; st = 0; lbs = 0; lhs = 0; addr = 0; wdata = 0; strb = 0;
    z_ld = 0; z_st = 0; z_lbs = 0; z_lhs = 0; z_addr = 0; z_wdata = 0; z_strb = 0;
    test_reset();
    test_store_word();
    test_byte();
    test_halfword();
    test_errors();
    test_busy_ignore();
    test_back_to_back();
    test_reset_midway();
    test_zero_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
